pkt_drop_filter: RTL and testbench

Store-and-forward packet filter placed directly downstream of the mini-firewall stage in the user data path. It buffers each packet, including its module headers. Packets in which any body word carries the drop marker ctrl value (0x54) are discarded in full and never reach the output. All other packets are forwarded unchanged to the next stage, e.g. the output port lookup.

---
 rtl/pkt_drop_filter.sv | 167 ++++++++++++++++
 tb/tb_pkt_drop_filter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_drop_filter.sv
// Store-and-forward packet filter: buffers whole packets and discards any packet with a drop-marker body word.
// Statistics counters are built only when PKT_DROP_FILTER_CNT_EN is defined; otherwise they read as zero.
module pkt_drop_filter #(
  parameter int unsigned           DATA_WIDTH     = 64,
  parameter int unsigned           CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned           BUF_ADDR_WIDTH = 9,
  parameter logic [CTRL_WIDTH-1:0] DROP_CTRL      = CTRL_WIDTH'(8'h54)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [31:0]           pkt_pass_cnt,
  output logic [31:0]           pkt_drop_cnt,
  output logic [31:0]           pkt_ovfl_cnt
);

  localparam int unsigned AW     = BUF_ADDR_WIDTH;
  localparam int unsigned DEPTH  = 1 << AW;
  localparam int unsigned WORD_W = CTRL_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_BODY    = 2'd1,
    ST_DISCARD = 2'd2
  } wr_state_e;

  wr_state_e         state_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     commit_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic              drop_q;
  logic              disc_body_q;
  logic              out_wr_q;
  logic [WORD_W-1:0] out_word_q;
  logic [WORD_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] used_c;
  logic [AW:0]   free_c;
  logic          ctrl_zero_c;
  logic          ctrl_mark_c;
  logic          is_eop_c;
  logic          ovfl_c;
  logic          wr_en_c;
  logic          rd_en_c;

  // Occupancy counts uncommitted words too, so a packet can never overrun unread data.
  assign used_c      = wr_ptr_q - rd_ptr_q;
  assign free_c      = (AW+1)'(DEPTH - 1) - (AW+1)'(used_c);
  assign ctrl_zero_c = (in_ctrl == '0);
  assign ctrl_mark_c = (in_ctrl == DROP_CTRL);
  assign is_eop_c    = (state_q == ST_BODY) && !ctrl_zero_c && !ctrl_mark_c;
  assign ovfl_c      = in_wr && (state_q != ST_DISCARD) && !is_eop_c && (free_c <= (AW+1)'(1));
  assign wr_en_c     = in_wr && (state_q != ST_DISCARD) && !ovfl_c;
  assign rd_en_c     = out_rdy && (rd_ptr_q != commit_ptr_q);

  assign in_rdy = reset && ((state_q == ST_DISCARD) || (free_c >= (AW+1)'(2)));

  // Write-side packet FSM: commit on clean EOP, roll back on marked EOP or overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_HDR;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      drop_q       <= 1'b0;
      disc_body_q  <= 1'b0;
    end else if (in_wr) begin
      case (state_q)
        ST_HDR, ST_BODY: begin
          if (ovfl_c) begin
            wr_ptr_q    <= commit_ptr_q;
            state_q     <= ST_DISCARD;
            disc_body_q <= (state_q == ST_BODY);
          end else if (is_eop_c) begin
            state_q <= ST_HDR;
            if (drop_q) begin
              wr_ptr_q <= commit_ptr_q;
            end else begin
              wr_ptr_q     <= wr_ptr_q + AW'(1);
              commit_ptr_q <= wr_ptr_q + AW'(1);
            end
          end else begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            if ((state_q == ST_HDR) && ctrl_zero_c) begin
              state_q <= ST_BODY;
              drop_q  <= 1'b0;
            end else if ((state_q == ST_BODY) && ctrl_mark_c) begin
              drop_q <= 1'b1;
            end
          end
        end
        ST_DISCARD: begin
          // Header words of a packet cut short before its body must not end the discard.
          if (ctrl_zero_c) begin
            disc_body_q <= 1'b1;
          end else if (disc_body_q && !ctrl_mark_c) begin
            state_q <= ST_HDR;
          end
        end
        default: state_q <= ST_HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_ptr_q] <= {in_ctrl, in_data};
    end
  end

  // Read side drains committed words only; the read data register doubles as the output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      out_wr_q   <= 1'b0;
      out_word_q <= '0;
    end else begin
      out_wr_q <= rd_en_c;
      if (rd_en_c) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        out_word_q <= mem_q[rd_ptr_q];
      end
    end
  end

  assign out_wr   = out_wr_q;
  assign out_data = out_word_q[DATA_WIDTH-1:0];
  assign out_ctrl = out_word_q[WORD_W-1:DATA_WIDTH];

`ifdef PKT_DROP_FILTER_CNT_EN
  logic        pass_evt_c;
  logic        drop_evt_c;
  logic [31:0] pass_cnt_q;
  logic [31:0] drop_cnt_q;
  logic [31:0] ovfl_cnt_q;

  assign pass_evt_c = wr_en_c && is_eop_c && !drop_q;
  assign drop_evt_c = wr_en_c && is_eop_c && drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
      ovfl_cnt_q <= '0;
    end else begin
      if (pass_evt_c) pass_cnt_q <= pass_cnt_q + 32'd1;
      if (drop_evt_c) drop_cnt_q <= drop_cnt_q + 32'd1;
      if (ovfl_c)     ovfl_cnt_q <= ovfl_cnt_q + 32'd1;
    end
  end

  assign pkt_pass_cnt = pass_cnt_q;
  assign pkt_drop_cnt = drop_cnt_q;
  assign pkt_ovfl_cnt = ovfl_cnt_q;
`else
  assign pkt_pass_cnt = '0;
  assign pkt_drop_cnt = '0;
  assign pkt_ovfl_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_drop_filter.sv
// Bench for pkt_drop_filter: directed packet table, multi-cycle corner sequences and a randomized run
// checked against a packet-level model (a packet is forwarded iff no body word carries the marker).
module tb_pkt_drop_filter;

  localparam int unsigned DW   = 64;
  localparam int unsigned CW   = 8;
  localparam logic [7:0]  MARK = 8'h54;

  typedef logic [CW+DW-1:0] word_t;
  typedef word_t wq_t[$];

  typedef struct {
    logic [7:0] hdr;
    int         nbody;
    int         nmark;
    logic [7:0] eop;
    bit         fwd;
    int         nwords;
  } vec_t;

`ifdef PKT_DROP_FILTER_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, s_rst_n;
  logic [DW-1:0] in_data, s_in_data, out_data, s_out_data;
  logic [CW-1:0] in_ctrl, s_in_ctrl, out_ctrl, s_out_ctrl;
  logic          in_wr, s_in_wr, in_rdy, s_in_rdy, out_wr, s_out_wr;
  logic          out_rdy = 1'b1;
  logic          s_out_rdy = 1'b1;
  logic [31:0]   pass_cnt, drop_cnt, ovfl_cnt, s_pass_cnt, s_drop_cnt, s_ovfl_cnt;

  pkt_drop_filter dut (
    .clk(clk), .reset(rst_n),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .pkt_pass_cnt(pass_cnt), .pkt_drop_cnt(drop_cnt), .pkt_ovfl_cnt(ovfl_cnt)
  );

  pkt_drop_filter #(.BUF_ADDR_WIDTH(4)) dut_s (
    .clk(clk), .reset(s_rst_n),
    .in_data(s_in_data), .in_ctrl(s_in_ctrl), .in_wr(s_in_wr), .in_rdy(s_in_rdy),
    .out_data(s_out_data), .out_ctrl(s_out_ctrl), .out_wr(s_out_wr), .out_rdy(s_out_rdy),
    .pkt_pass_cnt(s_pass_cnt), .pkt_drop_cnt(s_drop_cnt), .pkt_ovfl_cnt(s_ovfl_cnt)
  );

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    bp_viol = 0;
  int    mode = 0;
  int    s_mode = 0;
  logic  rdy_q, s_rdy_q;
  word_t got[$];
  word_t s_got[$];
  int    got_cyc[$];

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rdy_q   <= out_rdy;
    s_rdy_q <= s_out_rdy;
  end

  // Collect forwarded words; an out_wr is legal only if out_rdy was high at the edge that issued it.
  always @(negedge clk) begin
    if (out_wr === 1'b1) begin
      got.push_back({out_ctrl, out_data});
      got_cyc.push_back(cyc);
      if (rdy_q !== 1'b1) bp_viol++;
    end
    if (s_out_wr === 1'b1) begin
      s_got.push_back({s_out_ctrl, s_out_data});
      if (s_rdy_q !== 1'b1) bp_viol++;
    end
  end

  // out_rdy patterns: 0 = high, 1 = low, 2 = toggle, 3 = random
  always @(negedge clk) begin
    case (mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = 1'b0;
      2:       out_rdy = ~out_rdy;
      default: out_rdy = 1'($urandom_range(0, 1));
    endcase
    case (s_mode)
      0:       s_out_rdy = 1'b1;
      1:       s_out_rdy = 1'b0;
      2:       s_out_rdy = ~s_out_rdy;
      default: s_out_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check_int(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic word_t rand_word(input logic [7:0] c);
    return {c, $urandom(), $urandom()};
  endfunction

  task automatic mk_pkt(input logic [7:0] hdr, input int nbody, input int nmark,
                        input logic [7:0] eop, output wq_t p);
    p = {};
    p.push_back(rand_word(hdr));
    for (int k = 0; k < nbody; k++) p.push_back(rand_word(8'h00));
    for (int k = 0; k < nmark; k++) p.push_back(rand_word(MARK));
    p.push_back(rand_word(eop));
  endtask

  // Reference: forwarded iff no marker appears after the first ctrl==0 word.
  function automatic bit model_clean(input wq_t p);
    bit in_body = 1'b0;
    foreach (p[k]) begin
      if (!in_body) in_body = (p[k][71:64] == 8'h00);
      else if (p[k][71:64] == MARK) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic push(input bit sel, input word_t w, input bit honor, output int drv_cyc);
    int guard;
    guard = 0;
    while (honor && ((sel ? s_in_rdy : in_rdy) !== 1'b1) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      total++;
      bad++;
      $display("FAIL push_timeout: in_rdy low for %0d cycles, expected release", guard);
    end
    drv_cyc = cyc;
    if (sel) begin
      s_in_ctrl = w[71:64]; s_in_data = w[63:0]; s_in_wr = 1'b1;
    end else begin
      in_ctrl = w[71:64]; in_data = w[63:0]; in_wr = 1'b1;
    end
    @(negedge clk);
    if (sel) s_in_wr = 1'b0;
    else     in_wr = 1'b0;
  endtask

  task automatic send_pkt(input bit sel, input wq_t p, input bit honor, output int eop_cyc);
    int c;
    eop_cyc = 0;
    foreach (p[k]) begin
      push(sel, p[k], honor, c);
      eop_cyc = c;
    end
  endtask

  task automatic drain(input bit sel, input int base, input int n, input string name);
    int guard;
    guard = 0;
    while (((sel ? s_got.size() : got.size()) - base) < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    repeat (20) @(negedge clk);
    check_int({name, "_count"}, (sel ? s_got.size() : got.size()) - base, n);
  endtask

  task automatic cmp_stream(input bit sel, input int base, input wq_t exp, input string name);
    word_t a;
    foreach (exp[k]) begin
      if (sel) a = (base + k < s_got.size()) ? s_got[base + k] : 'x;
      else     a = (base + k < got.size())   ? got[base + k]   : 'x;
      check_word($sformatf("%s_w%0d", name, k), a, exp[k]);
    end
  endtask

  initial begin
    vec_t  vt[6];
    wq_t   p, p2, expq;
    int    base, ec, eop0, drv, exp_pass, exp_drop;
    bit    marked;
    int    nh, nb;
    logic [7:0] c;

    vt[0] = '{hdr: 8'hFF, nbody: 6, nmark: 0, eop: 8'h01, fwd: 1'b1, nwords: 8};
    vt[1] = '{hdr: 8'hFF, nbody: 4, nmark: 3, eop: 8'h10, fwd: 1'b0, nwords: 0};
    vt[2] = '{hdr: 8'hFF, nbody: 3, nmark: 0, eop: 8'h02, fwd: 1'b1, nwords: 5};
    vt[3] = '{hdr: 8'h54, nbody: 2, nmark: 0, eop: 8'h03, fwd: 1'b1, nwords: 4};
    vt[4] = '{hdr: 8'hFF, nbody: 1, nmark: 1, eop: 8'h80, fwd: 1'b0, nwords: 0};
    vt[5] = '{hdr: 8'h0F, nbody: 1, nmark: 0, eop: 8'hFE, fwd: 1'b1, nwords: 3};

    in_wr = 1'b0; in_data = '0; in_ctrl = '0;
    s_in_wr = 1'b0; s_in_data = '0; s_in_ctrl = '0;
    rst_n = 1'b0; s_rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check_int("rst_out_wr", out_wr, 0);
    check_int("rst_out_data", out_data, 0);
    check_int("rst_out_ctrl", out_ctrl, 0);
    check_int("rst_in_rdy", in_rdy, 0);
    check_int("rst_s_in_rdy", s_in_rdy, 0);
    check_int("rst_pass_cnt", pass_cnt, 0);
    rst_n = 1'b1; s_rst_n = 1'b1;
    @(negedge clk);
    check_int("post_rst_in_rdy", in_rdy, 1);

    // Table: clean / marked / clean interleave plus header-marker and minimal-packet corners
    base = got.size();
    expq = {};
    eop0 = 0;
    for (int i = 0; i < 6; i++) begin
      mk_pkt(vt[i].hdr, vt[i].nbody, vt[i].nmark, vt[i].eop, p);
      send_pkt(1'b0, p, 1'b1, ec);
      if (i == 0) eop0 = ec;
      if (vt[i].fwd) begin
        check_int($sformatf("tbl%0d_len", i), p.size(), vt[i].nwords);
        foreach (p[k]) expq.push_back(p[k]);
      end
    end
    drain(1'b0, base, 20, "tbl");
    check_int("tbl_latency", (got_cyc.size() > base) ? got_cyc[base] - eop0 : -1, 2);
    cmp_stream(1'b0, base, expq, "tbl");
    check_int("tbl_pass_cnt", pass_cnt, CNT_ON ? 4 : 0);
    check_int("tbl_drop_cnt", drop_cnt, CNT_ON ? 2 : 0);
    check_int("tbl_ovfl_cnt", ovfl_cnt, 0);

    // Backpressure: out_rdy toggles every cycle during a 20-word clean packet
    mode = 2;
    base = got.size();
    mk_pkt(8'hFF, 18, 0, 8'h01, p);
    send_pkt(1'b0, p, 1'b1, ec);
    drain(1'b0, base, 20, "bp");
    cmp_stream(1'b0, base, p, "bp");
    mode = 0;
    check_int("bp_pass_cnt", pass_cnt, CNT_ON ? 5 : 0);

    // Overflow on a 16-word buffer: 20-word packet with no reader, then an 8-word clean packet
    s_mode = 1;
    @(negedge clk);
    @(negedge clk);
    base = s_got.size();
    mk_pkt(8'hFF, 18, 0, 8'h01, p);
    send_pkt(1'b1, p, 1'b0, ec);
    s_mode = 0;
    mk_pkt(8'hFF, 6, 0, 8'h01, p2);
    send_pkt(1'b1, p2, 1'b1, ec);
    drain(1'b1, base, 8, "ovfl");
    cmp_stream(1'b1, base, p2, "ovfl");
    check_int("ovfl_ovfl_cnt", s_ovfl_cnt, CNT_ON ? 1 : 0);
    check_int("ovfl_pass_cnt", s_pass_cnt, CNT_ON ? 1 : 0);

    // Async reset while a packet streams out and another is mid-body
    mk_pkt(8'hFF, 6, 0, 8'h01, p);
    send_pkt(1'b0, p, 1'b1, ec);
    mk_pkt(8'hFF, 5, 0, 8'h02, p2);
    for (int k = 0; k < 3; k++) push(1'b0, p2[k], 1'b1, drv);
    check_int("prerst_out_wr", out_wr, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_int("arst_out_wr", out_wr, 0);
    check_int("arst_out_data", out_data, 0);
    check_int("arst_out_ctrl", out_ctrl, 0);
    check_int("arst_in_rdy", in_rdy, 0);
    check_int("arst_pass_cnt", pass_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = got.size();
    mk_pkt(8'hFF, 3, 0, 8'h01, p);
    send_pkt(1'b0, p, 1'b1, ec);
    drain(1'b0, base, 5, "arst");
    cmp_stream(1'b0, base, p, "arst");
    check_int("arst_pass_after", pass_cnt, CNT_ON ? 1 : 0);

    // Randomized traffic on the small buffer with random out_rdy
    s_mode = 3;
    base = s_got.size();
    expq = {};
    exp_pass = 1;
    exp_drop = 0;
    for (int n = 0; n < 60; n++) begin
      p = {};
      nh = $urandom_range(1, 2);
      for (int k = 0; k < nh; k++) p.push_back(rand_word(8'($urandom_range(1, 255))));
      nb = $urandom_range(1, 8);
      marked = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < nb; k++)
        p.push_back(rand_word((k > 0 && marked && $urandom_range(0, 1) == 1) ? MARK : 8'h00));
      if (marked) p.push_back(rand_word(MARK));
      c = 8'($urandom_range(1, 255));
      if (c == MARK) c = 8'h55;
      p.push_back(rand_word(c));
      if (model_clean(p)) begin
        exp_pass++;
        foreach (p[k]) expq.push_back(p[k]);
      end else begin
        exp_drop++;
      end
      send_pkt(1'b1, p, 1'b1, ec);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    s_mode = 0;
    drain(1'b1, base, expq.size(), "rnd");
    cmp_stream(1'b1, base, expq, "rnd");
    check_int("rnd_pass_cnt", s_pass_cnt, CNT_ON ? exp_pass : 0);
    check_int("rnd_drop_cnt", s_drop_cnt, CNT_ON ? exp_drop : 0);
    check_int("rnd_ovfl_cnt", s_ovfl_cnt, CNT_ON ? 1 : 0);

    check_int("bp_rule_violations", bp_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
